isdu_param: RTL and testbench

- Parametrised LC-3 instruction sequencing/decode unit: Moore FSM driving datapath load/gate/mux selects and SRAM strobes.
- Successor to the fixed-latency control unit, with these changes:
  - Memory wait length is a parameter, not replicated states.
  - Full LC-3 opcode set (adds LD, LDI, ST, STI, LEA, JSRR, TRAP).
  - A single shared read/write wait sequencer with a return-target register.
- Sits between the IR/BEN/NZP logic and the register file, ALU, PC, MAR and MDR.

---
 rtl/isdu_param.sv | 236 +++++++++++++++++++++++
 tb/tb_isdu_param.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/isdu_param.sv
// LC-3 sequencing/decode FSM with parametrised SRAM wait and shared RD/WR sequencer.
// Optional PAUSE states are built when ISDU_PAUSE_EN is defined.
module isdu_param #(
  parameter int MEM_WAIT = 3,
  parameter int CW = 4
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       IR_11,
  input  logic       BEN,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic       LD_LED,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic [1:0] PCMUX,
  output logic       DRMUX,
  output logic       SR1MUX,
  output logic       SR2MUX,
  output logic       ADDR1MUX,
  output logic [1:0] ADDR2MUX,
  output logic       MARMUX,
  output logic [1:0] ALUK,
  output logic       Mem_OE,
  output logic       Mem_WE,
  output logic       Halted_o
);

  typedef enum logic [4:0] {
    HALTED, S18, RD, WR, S35, S32, S1, S0, S22, S12, S4, S21,
    S14, S_APC, S_ABR, S_IND, S_INDW, S_DR, S23, S15, S15B, S_TPC
`ifdef ISDU_PAUSE_EN
    , P1, P2
`endif
  } state_t;

  typedef struct packed {
    logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
    logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic [1:0] pcmux;
    logic       drmux, sr1mux, sr2mux, addr1mux;
    logic [1:0] addr2mux;
    logic       marmux;
    logic [1:0] aluk;
    logic       mem_oe, mem_we;
  } ctl_t;

  state_t state, next, ret, next_ret;
  logic [CW-1:0] cnt;
  ctl_t c;

  wire last = (cnt == '0);
  wire in_mem = (state == RD) || (state == WR);
  wire to_mem = (next == RD) || (next == WR);

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state <= HALTED;
      ret   <= S35;
      cnt   <= '0;
    end else begin
      state <= next;
      ret   <= next_ret;
      if (to_mem && !in_mem)
        cnt <= CW'(MEM_WAIT - 1);
      else if (!last)
        cnt <= cnt - CW'(1);
    end
  end

  always_comb begin
    c        = '0;
    next     = state;
    next_ret = ret;
    case (state)
      HALTED: if (Run) next = S18;
      S18: begin
        c.gate_pc = 1'b1; c.ld_mar = 1'b1; c.ld_pc = 1'b1;
        next = RD; next_ret = S35;
      end
      RD: begin
        c.mem_oe = 1'b1;
        if (last) begin
          c.ld_mdr = 1'b1;
          next = ret;
        end
      end
      WR: begin
        c.mem_we = 1'b1;
        if (last) next = S18;
      end
      S35: begin
        c.gate_mdr = 1'b1; c.ld_ir = 1'b1;
        next = S32;
      end
      S32: begin
        c.ld_ben = 1'b1;
        case (Opcode)
          4'b0001, 4'b0101, 4'b1001: next = S1;
          4'b0000: next = S0;
          4'b1100: next = S12;
          4'b0100: next = S4;
          4'b1110: next = S14;
          4'b0010, 4'b1010, 4'b0011, 4'b1011: next = S_APC;
          4'b0110, 4'b0111: next = S_ABR;
          4'b1111: next = S15;
`ifdef ISDU_PAUSE_EN
          4'b1101: next = P1;
`endif
          default: next = S18;
        endcase
      end
      S1: begin
        c.sr1mux = 1'b1; c.sr2mux = IR_5;
        c.gate_alu = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1;
        c.aluk = (Opcode == 4'b0101) ? 2'b01 :
                 (Opcode == 4'b1001) ? 2'b10 : 2'b00;
        next = S18;
      end
      S0: next = BEN ? S22 : S18;
      S22: begin
        c.addr2mux = 2'b10; c.pcmux = 2'b10; c.ld_pc = 1'b1;
        next = S18;
      end
      S12: begin
        c.sr1mux = 1'b1; c.addr1mux = 1'b1;
        c.pcmux = 2'b10; c.ld_pc = 1'b1;
        next = S18;
      end
      S4: begin
        c.gate_pc = 1'b1; c.drmux = 1'b1; c.ld_reg = 1'b1;
        next = S21;
      end
      S21: begin
        if (IR_11) c.addr2mux = 2'b11;
        else begin c.sr1mux = 1'b1; c.addr1mux = 1'b1; end
        c.pcmux = 2'b10; c.ld_pc = 1'b1;
        next = S18;
      end
      S14: begin
        c.addr2mux = 2'b10; c.gate_marmux = 1'b1;
        c.ld_reg = 1'b1; c.ld_cc = 1'b1;
        next = S18;
      end
      S_APC: begin
        c.addr2mux = 2'b10; c.gate_marmux = 1'b1; c.ld_mar = 1'b1;
        case (Opcode)
          4'b0010: begin next = RD; next_ret = S_DR;   end
          4'b1010: begin next = RD; next_ret = S_IND;  end
          4'b1011: begin next = RD; next_ret = S_INDW; end
          default: next = S23;
        endcase
      end
      S_ABR: begin
        c.sr1mux = 1'b1; c.addr1mux = 1'b1; c.addr2mux = 2'b01;
        c.gate_marmux = 1'b1; c.ld_mar = 1'b1;
        if (Opcode == 4'b0110) begin next = RD; next_ret = S_DR; end
        else next = S23;
      end
      S_IND: begin
        c.gate_mdr = 1'b1; c.ld_mar = 1'b1;
        next = RD; next_ret = S_DR;
      end
      S_INDW: begin
        c.gate_mdr = 1'b1; c.ld_mar = 1'b1;
        next = S23;
      end
      S_DR: begin
        c.gate_mdr = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1;
        next = S18;
      end
      S23: begin
        c.aluk = 2'b11; c.gate_alu = 1'b1; c.ld_mdr = 1'b1;
        next = WR;
      end
      // R7 cannot be written here: the bus is busy with the trap vector
      S15: begin
        c.marmux = 1'b1; c.gate_marmux = 1'b1; c.ld_mar = 1'b1;
        next = S15B;
      end
      S15B: begin
        c.gate_pc = 1'b1; c.drmux = 1'b1; c.ld_reg = 1'b1;
        next = RD; next_ret = S_TPC;
      end
      S_TPC: begin
        c.gate_mdr = 1'b1; c.pcmux = 2'b01; c.ld_pc = 1'b1;
        next = S18;
      end
`ifdef ISDU_PAUSE_EN
      P1: begin
        c.ld_led = 1'b1;
        if (Continue) next = P2;
      end
      P2: if (!Continue) next = S18;
`endif
      default: next = HALTED;
    endcase
    if (!Reset_n) c = '0;
  end

  assign LD_MAR     = c.ld_mar;
  assign LD_MDR     = c.ld_mdr;
  assign LD_IR      = c.ld_ir;
  assign LD_BEN     = c.ld_ben;
  assign LD_CC      = c.ld_cc;
  assign LD_REG     = c.ld_reg;
  assign LD_PC      = c.ld_pc;
  assign LD_LED     = c.ld_led;
  assign GatePC     = c.gate_pc;
  assign GateMDR    = c.gate_mdr;
  assign GateALU    = c.gate_alu;
  assign GateMARMUX = c.gate_marmux;
  assign PCMUX      = c.pcmux;
  assign DRMUX      = c.drmux;
  assign SR1MUX     = c.sr1mux;
  assign SR2MUX     = c.sr2mux;
  assign ADDR1MUX   = c.addr1mux;
  assign ADDR2MUX   = c.addr2mux;
  assign MARMUX     = c.marmux;
  assign ALUK       = c.aluk;
  assign Mem_OE     = c.mem_oe;
  assign Mem_WE     = c.mem_we;
  assign Halted_o   = !Reset_n || (state == HALTED);

endmodule

// File: tb/tb_isdu_param.sv
// Directed bench for isdu_param: per-cycle control-word sequences
// for MEM_WAIT=3 and MEM_WAIT=1 builds.
module tb_isdu_param;

  localparam logic [25:0] M_LD_MAR = 26'd1 << 0;
  localparam logic [25:0] M_LD_MDR = 26'd1 << 1;
  localparam logic [25:0] M_LD_IR  = 26'd1 << 2;
  localparam logic [25:0] M_LD_BEN = 26'd1 << 3;
  localparam logic [25:0] M_LD_CC  = 26'd1 << 4;
  localparam logic [25:0] M_LD_REG = 26'd1 << 5;
  localparam logic [25:0] M_LD_PC  = 26'd1 << 6;
  localparam logic [25:0] M_LD_LED = 26'd1 << 7;
  localparam logic [25:0] M_GPC    = 26'd1 << 8;
  localparam logic [25:0] M_GMDR   = 26'd1 << 9;
  localparam logic [25:0] M_GALU   = 26'd1 << 10;
  localparam logic [25:0] M_GMM    = 26'd1 << 11;
  localparam logic [25:0] PC_BUS   = 26'd1 << 12;
  localparam logic [25:0] PC_ADR   = 26'd2 << 12;
  localparam logic [25:0] M_DR     = 26'd1 << 14;
  localparam logic [25:0] M_SR1    = 26'd1 << 15;
  localparam logic [25:0] M_SR2    = 26'd1 << 16;
  localparam logic [25:0] M_A1     = 26'd1 << 17;
  localparam logic [25:0] A2_OFF6  = 26'd1 << 18;
  localparam logic [25:0] A2_OFF9  = 26'd2 << 18;
  localparam logic [25:0] A2_OFF11 = 26'd3 << 18;
  localparam logic [25:0] M_MARMUX = 26'd1 << 20;
  localparam logic [25:0] ALU_AND  = 26'd1 << 21;
  localparam logic [25:0] ALU_NOT  = 26'd2 << 21;
  localparam logic [25:0] ALU_PASS = 26'd3 << 21;
  localparam logic [25:0] M_OE     = 26'd1 << 23;
  localparam logic [25:0] M_WE     = 26'd1 << 24;
  localparam logic [25:0] M_HALT   = 26'd1 << 25;

  localparam logic [25:0] E_HALT = M_HALT;
  localparam logic [25:0] E_S18  = M_GPC | M_LD_MAR | M_LD_PC;
  localparam logic [25:0] E_RD   = M_OE;
  localparam logic [25:0] E_RDL  = M_OE | M_LD_MDR;
  localparam logic [25:0] E_WR   = M_WE;
  localparam logic [25:0] E_S35  = M_GMDR | M_LD_IR;
  localparam logic [25:0] E_S32  = M_LD_BEN;
  localparam logic [25:0] E_ADDI = M_SR1 | M_SR2 | M_GALU | M_LD_REG | M_LD_CC;
  localparam logic [25:0] E_ANDR = M_SR1 | ALU_AND | M_GALU | M_LD_REG | M_LD_CC;
  localparam logic [25:0] E_NOTI = M_SR1 | M_SR2 | ALU_NOT | M_GALU | M_LD_REG | M_LD_CC;
  localparam logic [25:0] E_S0   = 26'd0;
  localparam logic [25:0] E_S22  = A2_OFF9 | PC_ADR | M_LD_PC;
  localparam logic [25:0] E_S4   = M_GPC | M_DR | M_LD_REG;
  localparam logic [25:0] E_S21J = A2_OFF11 | PC_ADR | M_LD_PC;
  localparam logic [25:0] E_S21R = M_SR1 | M_A1 | PC_ADR | M_LD_PC;
  localparam logic [25:0] E_APC  = A2_OFF9 | M_GMM | M_LD_MAR;
  localparam logic [25:0] E_ABR  = M_SR1 | M_A1 | A2_OFF6 | M_GMM | M_LD_MAR;
  localparam logic [25:0] E_IND  = M_GMDR | M_LD_MAR;
  localparam logic [25:0] E_DR   = M_GMDR | M_LD_REG | M_LD_CC;
  localparam logic [25:0] E_S23  = ALU_PASS | M_GALU | M_LD_MDR;
  localparam logic [25:0] E_S15  = M_MARMUX | M_GMM | M_LD_MAR;
  localparam logic [25:0] E_S15B = M_GPC | M_DR | M_LD_REG;
  localparam logic [25:0] E_TPC  = M_GMDR | PC_BUS | M_LD_PC;

  logic clk = 1'b0;
  logic rst3, rst1, run3, run1, cont, ir5, ir11, ben;
  logic [3:0] opc;
  logic [25:0] o3, o1;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  isdu_param #(.MEM_WAIT(3), .CW(4)) u3 (
    .Clk(clk), .Reset_n(rst3), .Run(run3), .Continue(cont),
    .Opcode(opc), .IR_5(ir5), .IR_11(ir11), .BEN(ben),
    .LD_MAR(o3[0]), .LD_MDR(o3[1]), .LD_IR(o3[2]), .LD_BEN(o3[3]),
    .LD_CC(o3[4]), .LD_REG(o3[5]), .LD_PC(o3[6]), .LD_LED(o3[7]),
    .GatePC(o3[8]), .GateMDR(o3[9]), .GateALU(o3[10]),
    .GateMARMUX(o3[11]), .PCMUX(o3[13:12]), .DRMUX(o3[14]),
    .SR1MUX(o3[15]), .SR2MUX(o3[16]), .ADDR1MUX(o3[17]),
    .ADDR2MUX(o3[19:18]), .MARMUX(o3[20]), .ALUK(o3[22:21]),
    .Mem_OE(o3[23]), .Mem_WE(o3[24]), .Halted_o(o3[25])
  );

  isdu_param #(.MEM_WAIT(1), .CW(4)) u1 (
    .Clk(clk), .Reset_n(rst1), .Run(run1), .Continue(cont),
    .Opcode(opc), .IR_5(ir5), .IR_11(ir11), .BEN(ben),
    .LD_MAR(o1[0]), .LD_MDR(o1[1]), .LD_IR(o1[2]), .LD_BEN(o1[3]),
    .LD_CC(o1[4]), .LD_REG(o1[5]), .LD_PC(o1[6]), .LD_LED(o1[7]),
    .GatePC(o1[8]), .GateMDR(o1[9]), .GateALU(o1[10]),
    .GateMARMUX(o1[11]), .PCMUX(o1[13:12]), .DRMUX(o1[14]),
    .SR1MUX(o1[15]), .SR2MUX(o1[16]), .ADDR1MUX(o1[17]),
    .ADDR2MUX(o1[19:18]), .MARMUX(o1[20]), .ALUK(o1[22:21]),
    .Mem_OE(o1[23]), .Mem_WE(o1[24]), .Halted_o(o1[25])
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst3 = 1'b0;
    step();
    checks++;
    if (o3 !== E_HALT) begin
      failures++;
      $display("FAIL reset_low got=%h exp=%h", o3, E_HALT);
    end
    rst3 = 1'b1;
    cont = 1'b1;
    step();
    step();
    checks++;
    if (o3 !== E_HALT) begin
      failures++;
      $display("FAIL halted_hold got=%h exp=%h", o3, E_HALT);
    end
    cont = 1'b0;
    run3 = 1'b1;
    step();
    run3 = 1'b0;
  endtask

  task automatic test_fetch_ld;
    logic [25:0] seq [$];
    opc = 4'b0010;
    seq = '{E_S18, E_RD, E_RD, E_RDL, E_S35, E_S32, E_APC,
            E_RD, E_RD, E_RDL, E_DR, E_S18};
    foreach (seq[i]) begin
      checks++;
      if (o3 !== seq[i]) begin
        failures++;
        $display("FAIL ld cyc=%0d got=%h exp=%h", i, o3, seq[i]);
      end
      if (i < seq.size() - 1) step();
    end
  endtask

  task automatic test_ldi;
    logic [25:0] seq [$];
    opc = 4'b1010;
    seq = '{E_S18, E_RD, E_RD, E_RDL, E_S35, E_S32, E_APC,
            E_RD, E_RD, E_RDL, E_IND, E_RD, E_RD, E_RDL,
            E_DR, E_S18};
    foreach (seq[i]) begin
      checks++;
      if (o3 !== seq[i]) begin
        failures++;
        $display("FAIL ldi cyc=%0d got=%h exp=%h", i, o3, seq[i]);
      end
      if (i < seq.size() - 1) step();
    end
  endtask

  task automatic test_alu;
    logic [25:0] seq [$];
    for (int k = 0; k < 2; k++) begin
      opc = (k == 0) ? 4'b0101 : 4'b1001;
      ir5 = (k == 0) ? 1'b0 : 1'b1;
      seq = '{E_S18, E_RD, E_RD, E_RDL, E_S35, E_S32,
              (k == 0) ? E_ANDR : E_NOTI, E_S18};
      foreach (seq[i]) begin
        checks++;
        if (o3 !== seq[i]) begin
          failures++;
          $display("FAIL alu%0d cyc=%0d got=%h exp=%h", k, i, o3, seq[i]);
        end
        if (i < seq.size() - 1) step();
      end
    end
    ir5 = 1'b0;
  endtask

  task automatic test_br;
    logic [25:0] seq [$];
    opc = 4'b0000;
    for (int k = 0; k < 2; k++) begin
      ben = (k == 1);
      if (k == 0)
        seq = '{E_S18, E_RD, E_RD, E_RDL, E_S35, E_S32, E_S0, E_S18};
      else
        seq = '{E_S18, E_RD, E_RD, E_RDL, E_S35, E_S32, E_S0, E_S22, E_S18};
      foreach (seq[i]) begin
        checks++;
        if (o3 !== seq[i]) begin
          failures++;
          $display("FAIL br_ben%0d cyc=%0d got=%h exp=%h", k, i, o3, seq[i]);
        end
        if (i < seq.size() - 1) step();
      end
    end
    ben = 1'b0;
  endtask

  task automatic test_jsr;
    logic [25:0] seq [$];
    opc = 4'b0100;
    for (int k = 0; k < 2; k++) begin
      ir11 = (k == 0);
      seq = '{E_S18, E_RD, E_RD, E_RDL, E_S35, E_S32, E_S4,
              (k == 0) ? E_S21J : E_S21R, E_S18};
      foreach (seq[i]) begin
        checks++;
        if (o3 !== seq[i]) begin
          failures++;
          $display("FAIL jsr%0d cyc=%0d got=%h exp=%h", k, i, o3, seq[i]);
        end
        if (i < seq.size() - 1) step();
      end
    end
    ir11 = 1'b0;
  endtask

  task automatic test_trap;
    logic [25:0] seq [$];
    opc = 4'b1111;
    seq = '{E_S18, E_RD, E_RD, E_RDL, E_S35, E_S32, E_S15, E_S15B,
            E_RD, E_RD, E_RDL, E_TPC, E_S18};
    foreach (seq[i]) begin
      checks++;
      if (o3 !== seq[i]) begin
        failures++;
        $display("FAIL trap cyc=%0d got=%h exp=%h", i, o3, seq[i]);
      end
      if (i < seq.size() - 1) step();
    end
  endtask

  task automatic test_pause;
    logic [25:0] seq [$];
    opc = 4'b1101;
`ifdef ISDU_PAUSE_EN
    seq = '{E_S18, E_RD, E_RD, E_RDL, E_S35, E_S32, M_LD_LED, M_LD_LED};
`else
    cont = 1'b1;
    seq = '{E_S18, E_RD, E_RD, E_RDL, E_S35, E_S32, E_S18};
`endif
    foreach (seq[i]) begin
      checks++;
      if (o3 !== seq[i]) begin
        failures++;
        $display("FAIL pause cyc=%0d got=%h exp=%h", i, o3, seq[i]);
      end
      if (i < seq.size() - 1) step();
    end
`ifdef ISDU_PAUSE_EN
    cont = 1'b1;
    step();
    checks++;
    if (o3 !== 26'd0) begin
      failures++;
      $display("FAIL pause_p2 got=%h exp=%h", o3, 26'd0);
    end
    cont = 1'b0;
    step();
    checks++;
    if (o3 !== E_S18) begin
      failures++;
      $display("FAIL pause_exit got=%h exp=%h", o3, E_S18);
    end
`endif
    cont = 1'b0;
  endtask

  task automatic test_sti;
    logic [25:0] seq [$];
    opc = 4'b1011;
    seq = '{E_S18, E_RD, E_RD, E_RDL, E_S35, E_S32, E_APC,
            E_RD, E_RD, E_RDL, E_IND, E_S23, E_WR, E_WR, E_WR, E_S18};
    foreach (seq[i]) begin
      checks++;
      if (o3 !== seq[i]) begin
        failures++;
        $display("FAIL sti cyc=%0d got=%h exp=%h", i, o3, seq[i]);
      end
      if (i < seq.size() - 1) step();
    end
  endtask

  task automatic test_reset_mid_wr;
    logic [25:0] seq [$];
    opc = 4'b0011;
    seq = '{E_S18, E_RD, E_RD, E_RDL, E_S35, E_S32, E_APC, E_S23, E_WR};
    foreach (seq[i]) begin
      checks++;
      if (o3 !== seq[i]) begin
        failures++;
        $display("FAIL st cyc=%0d got=%h exp=%h", i, o3, seq[i]);
      end
      if (i < seq.size() - 1) step();
    end
    rst3 = 1'b0;
    #1;
    checks++;
    if (o3 !== E_HALT) begin
      failures++;
      $display("FAIL rst_mid_wr_comb got=%h exp=%h", o3, E_HALT);
    end
    step();
    rst3 = 1'b1;
    #1;
    checks++;
    if (o3 !== E_HALT) begin
      failures++;
      $display("FAIL rst_mid_wr_state got=%h exp=%h", o3, E_HALT);
    end
    step();
    checks++;
    if (o3 !== E_HALT) begin
      failures++;
      $display("FAIL rst_mid_wr_hold got=%h exp=%h", o3, E_HALT);
    end
  endtask

  task automatic test_mem_wait1;
    logic [25:0] seq [$];
    rst1 = 1'b0;
    step();
    checks++;
    if (o1 !== E_HALT) begin
      failures++;
      $display("FAIL w1_reset got=%h exp=%h", o1, E_HALT);
    end
    rst1 = 1'b1;
    opc = 4'b0001;
    ir5 = 1'b1;
    run1 = 1'b1;
    step();
    run1 = 1'b0;
    seq = '{E_S18, E_RDL, E_S35, E_S32, E_ADDI, E_S18};
    foreach (seq[i]) begin
      checks++;
      if (o1 !== seq[i]) begin
        failures++;
        $display("FAIL w1_add cyc=%0d got=%h exp=%h", i, o1, seq[i]);
      end
      if (i < seq.size() - 1) step();
    end
    opc = 4'b0111;
    ir5 = 1'b0;
    seq = '{E_S18, E_RDL, E_S35, E_S32, E_ABR, E_S23, E_WR, E_S18};
    foreach (seq[i]) begin
      checks++;
      if (o1 !== seq[i]) begin
        failures++;
        $display("FAIL w1_str cyc=%0d got=%h exp=%h", i, o1, seq[i]);
      end
      if (i < seq.size() - 1) step();
    end
  endtask

  initial begin
    rst3 = 1'b0; rst1 = 1'b0; run3 = 1'b0; run1 = 1'b0;
    cont = 1'b0; ir5 = 1'b0; ir11 = 1'b0; ben = 1'b0;
    opc = 4'b0000;
    step();
    test_reset();
    test_fetch_ld();
    test_ldi();
    test_alu();
    test_br();
    test_jsr();
    test_trap();
    test_pause();
    test_sti();
    test_reset_mid_wr();
    test_mem_wait1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
